muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS EX stage, sitting beside the ALU.
- Sequences a 32-cycle shift-add multiplier and a restoring divider.
- Owns the HI/LO registers and serves mfhi/mflo/mthi/mtlo.
- Drives a stall to the hazard unit while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  EX stage holds an R-type instruction with a muldiv-class funct.
- i_funct  in  6  instruction funct field.
- i_rs  in  WIDTH  rs operand: dividend or multiplicand, or mthi/mtlo source.
- i_rt  in  WIDTH  rt operand: divisor or multiplier.
- i_flush  in  1  pipeline flush; aborts any in-flight operation.
- o_stall  out  1  stall request to the hazard unit.
- o_result  out  WIDTH  mfhi/mflo read data.
- o_busy  out  1  high while the state is not IDLE.

Behaviour:
- Funct codes:
  - mult 011000, multu 011001, div 011010, divu 011011.
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
  - Any other funct while i_valid is high is ignored; no state change and o_stall=0.
- Reset values (asynchronous):
  - State IDLE; HI=0, LO=0; counter=0.
  - o_busy=0, o_stall=0, o_result=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - On i_valid with mult/multu/div/divu and i_flush=0, the op is accepted at the clock edge.
  - On acceptance, latch op type, signedness and operand magnitudes (absolute values if signed), load counter=WIDTH-1, and go to RUN.
- RUN:
  - One iteration per cycle.
  - Multiply: 2*WIDTH accumulator, conditional add of the multiplicand, then shift right.
  - Divide: restoring shift-subtract step.
  - When the counter reaches 0, go to FIX; otherwise decrement the counter.
- FIX:
  - One cycle. Apply sign correction and write HI/LO at the closing edge, then go to IDLE.
  - Signed multiply: negate the 2*WIDTH product if rs and rt signs differ.
  - Signed divide: quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - Multiply result: HI=product[2W-1:W], LO=product[W-1:0].
  - Divide result: LO=quotient, HI=remainder.
- Latency:
  - Accept edge, then WIDTH RUN cycles, then 1 FIX cycle.
  - o_busy is high for exactly WIDTH+1 cycles after the accept edge.
  - A dependent mfhi/mflo first gets the new value in the cycle after FIX.
- Divide by zero: LO=all ones, HI=i_rs as latched (unmodified, sign-independent). No exception.
- Signed overflow: div of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
- mthi/mtlo:
  - In IDLE, write i_rs into HI or LO at the edge; takes one cycle; o_stall=0.
  - In RUN or FIX, o_stall=1 and no write happens.
- mfhi/mflo:
  - In IDLE, o_result is combinational HI or LO; o_stall=0. o_result is 0 for other functs.
  - In RUN or FIX, o_stall=1 and o_result=0.
- Any muldiv-class funct with i_valid while busy: o_stall=1 and the op is not accepted. The pipeline re-presents it.
- o_stall is combinational: i_valid AND (muldiv-class funct) AND o_busy.
- i_flush:
  - Any state: the next state is IDLE and HI/LO stay unchanged.
  - A flush coinciding with the FIX closing edge suppresses the write.
  - A flush in IDLE blocks acceptance in that cycle.
- Reset mid-operation: immediate IDLE, HI=LO=0.

Decomposition:
- Package muldiv_pkg holds:
  - the eight funct localparams;
  - the state encoding (IDLE=2'd0, RUN=2'd1, FIX=2'd2);
  - an is_muldiv_class function.
- One sub-module, muldiv_iter_step: a combinational single-iteration datapath (add-shift / subtract-restore) selected by op type.
- The FSM, counter and HI/LO registers stay in muldiv_unit.

Test Plan:
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF:
  - o_busy high for 33 cycles.
  - Then HI=0xFFFFFFFE, LO=0x00000001.
- mult rs=0xFFFFFFFE (-2), rt=3:
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - mflo issued during busy gives o_stall=1 until IDLE, then o_result=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (-7), rt=2:
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu same operands: LO=0x7FFFFFFC, HI=1.
- divu rs=0x1234, rt=0:
  - LO=0xFFFFFFFF, HI=0x1234.
  - div 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi 0xAAAA in IDLE, then mult 5×6 with i_flush at RUN cycle 10:
  - Returns to IDLE; HI=0xAAAA, LO unchanged.
  - A second mult started while busy is held with o_stall=1.
- Reset asserted mid-RUN, async between clock edges:
  - o_busy=0 and HI=LO=0 immediately.
  - A new multu 3×4 after release gives LO=12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct codes, FSM encoding and decode helpers for the muldiv unit
package muldiv_pkg;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
  function automatic logic is_muldiv_class(input logic [5:0] f);
    return f[5:3] == 3'b010 && f[2] == 1'b0 || f[5:2] == 4'b0110;
  endfunction
  function automatic logic is_arith(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction
endpackage

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step: one shift-add multiply or restoring divide iteration
module muldiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] sum, sh;
  logic [WIDTH-1:0] rem_sub;
  logic ge;
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_sub = sh[WIDTH-1:0] - opnd;
    ge = sh >= {1'b0, opnd};
    acc_nxt = is_div ? {ge ? rem_sub : sh[WIDTH-1:0], acc[WIDTH-2:0], ge} : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative mult/div sequencer owning HI/LO, with pipeline stall
// acc holds {hi,lo} partial product while multiplying, {remainder,quotient} while dividing
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [5:0]       i_funct,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  input  logic             i_flush,
  output logic             o_stall,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
  logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, rs_q, rs_d;
  logic [WIDTH-1:0] rs_mag, rt_mag, quo, rem;
  logic div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic sgn, idle, accept;

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div (div_q),
    .acc    (acc_q),
    .opnd   (opnd_q),
    .acc_nxt(acc_step)
  );

  always_comb begin
    idle = state_q == IDLE;
    sgn = ~i_funct[0];
    rs_mag = (sgn & i_rs[WIDTH-1]) ? -i_rs : i_rs;
    rt_mag = (sgn & i_rt[WIDTH-1]) ? -i_rt : i_rt;
    accept = idle & i_valid & ~i_flush & is_arith(i_funct);
    prod = qneg_q ? -acc_q : acc_q;
    quo = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opnd_d = opnd_q;
    hi_d = hi_q;
    lo_d = lo_q;
    rs_d = rs_q;
    div_d = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    if (i_flush) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = RUN;
      cnt_d = CNT_W'(WIDTH - 1);
      div_d = i_funct[1];
      opnd_d = i_funct[1] ? rt_mag : rs_mag;
      acc_d = {{WIDTH{1'b0}}, i_funct[1] ? rs_mag : rt_mag};
      qneg_d = sgn & (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
      rneg_d = sgn & i_rs[WIDTH-1];
      dz_d = i_rt == '0;
      rs_d = i_rs;
    end else if (idle & i_valid) begin
      hi_d = i_funct == F_MTHI ? i_rs : hi_q;
      lo_d = i_funct == F_MTLO ? i_rs : lo_q;
    end else if (state_q == RUN) begin
      acc_d = acc_step;
      state_d = cnt_q == '0 ? FIX : RUN;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
    end else if (state_q == FIX) begin
      state_d = IDLE;
      hi_d = div_q ? (dz_q ? rs_q : rem) : prod[2*WIDTH-1:WIDTH];
      lo_d = div_q ? (dz_q ? '1 : quo) : prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opnd_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      rs_q <= '0;
      div_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opnd_q <= opnd_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      rs_q <= rs_d;
      div_q <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q <= dz_d;
    end
  end

  always_comb begin
    o_busy = state_q != IDLE;
    o_stall = i_valid & is_muldiv_class(i_funct) & o_busy;
    o_result = (idle & i_valid & i_funct == F_MFHI) ? hi_q :
               (idle & i_valid & i_funct == F_MFLO) ? lo_q : '0;
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic clk = 1'b0, reset = 1'b0, i_valid = 1'b0, i_flush = 1'b0;
  logic [5:0] i_funct = '0;
  logic [31:0] i_rs = '0, i_rt = '0;
  logic o_stall, o_busy;
  logic [31:0] o_result;
  logic [63:0] sb[$];
  int tests = 0, fails = 0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_funct(i_funct), .i_rs(i_rs),
    .i_rt(i_rt), .i_flush(i_flush), .o_stall(o_stall), .o_result(o_result), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_;
    sa = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    if (f == F_MULT) return sa * sb_;
    if (f == F_MULTU) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (f == F_DIVU) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    i_valid = 1'b1; i_funct = f; i_rs = a; i_rt = b;
    @(negedge clk);
    i_valid = 1'b0; i_funct = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [5:0] f, output logic [31:0] v);
    i_valid = 1'b1; i_funct = f;
    #1 v = o_result;
    i_valid = 1'b0; i_funct = '0;
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int n;
    logic [63:0] e;
    logic [31:0] h, l;
    sb.push_back(exp);
    start(f, a, b);
    wait_idle(n);
    chk({tag, "_busy_len"}, n, 33);
    e = sb.pop_front();
    rd(F_MFHI, h);
    rd(F_MFLO, l);
    chk({tag, "_hi"}, h, e[63:32]);
    chk({tag, "_lo"}, l, e[31:0]);
  endtask

  initial begin
    int n;
    logic [31:0] h, l, a, b;
    logic [5:0] f;
    logic [63:0] e;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_result", o_result, 0);
    reset = 1'b0;
    rd(F_MFHI, h);
    chk("rst_hi", h, 0);
    rd(F_MFLO, l);
    chk("rst_lo", l, 0);

    run_op("multu_ff", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

    sb.push_back(64'hFFFF_FFFF_FFFF_FFFA);
    start(F_MULT, 32'hFFFF_FFFE, 32'd3);
    i_valid = 1'b1; i_funct = F_MFLO;
    #1 chk("mflo_stall_busy", o_stall, 1);
    chk("mflo_result_busy", o_result, 0);
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mflo_stall_len", n, 33);
    #1 chk("mflo_stall_idle", o_stall, 0);
    e = sb.pop_front();
    chk("mflo_after", o_result, e[31:0]);
    i_valid = 1'b0; i_funct = '0;
    rd(F_MFHI, h);
    chk("mult_neg_hi", h, e[63:32]);

    run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_big", F_DIVU, 32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC);
    run_op("divu_zero", F_DIVU, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
    run_op("div_zero_neg", F_DIV, 32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

    @(negedge clk);
    i_valid = 1'b1; i_funct = 6'b100000; i_rs = 32'h55;
    #1 chk("ign_stall", o_stall, 0);
    chk("ign_result", o_result, 0);
    @(negedge clk);
    i_valid = 1'b0;
    chk("ign_busy", o_busy, 0);

    @(negedge clk);
    i_valid = 1'b1; i_funct = F_MTHI; i_rs = 32'hAAAA;
    @(negedge clk);
    i_valid = 1'b0;
    rd(F_MFHI, h);
    chk("mthi_hi", h, 32'hAAAA);
    start(F_MULT, 32'd5, 32'd6);
    repeat (8) @(negedge clk);
    i_valid = 1'b1; i_funct = F_MULT; i_rs = 32'd7; i_rt = 32'd8;
    #1 chk("second_mult_stall", o_stall, 1);
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_busy", o_busy, 0);
    @(negedge clk);
    chk("flush_no_accept", o_busy, 0);
    rd(F_MFHI, h);
    chk("flush_hi", h, 32'hAAAA);
    rd(F_MFLO, l);
    chk("flush_lo", l, 32'h8000_0000);

    @(negedge clk);
    i_valid = 1'b1; i_funct = F_MULTU; i_rs = 32'd9; i_rt = 32'd9; i_flush = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_idle_block", o_busy, 0);

    start(F_MULTU, 32'hFFFF, 32'hFFFF);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("async_rst_busy", o_busy, 0);
    rd(F_MFHI, h);
    chk("async_rst_hi", h, 0);
    rd(F_MFLO, l);
    chk("async_rst_lo", l, 0);
    @(negedge clk);
    reset = 1'b0;
    run_op("multu_after_rst", F_MULTU, 32'd3, 32'd4, 64'd12);

    for (int k = 0; k < 8; k++) begin
      f = {4'b0110, 2'($urandom_range(0, 3))};
      a = $urandom;
      b = (k == 3) ? 32'd0 : $urandom >> $urandom_range(0, 24);
      run_op($sformatf("rand%0d", k), f, a, b, model(f, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
